// File: rtl/btb_2way_if.sv
// Fetch-lookup, execute-update and flush-control signals of the 2-way BTB.
// The BTB itself connects through the slave modport.
interface btb_2way_if;
  logic [31:0] lk_pc_i;
  logic        hit_o;
  logic        pred_taken_o;
  logic [31:0] target_o;
  logic        upd_en_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        flush_i;
  logic        busy_o;

  modport slave (
    input  lk_pc_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i, flush_i,
    output hit_o, pred_taken_o, target_o, busy_o
  );

  modport master (
    output lk_pc_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i, flush_i,
    input  hit_o, pred_taken_o, target_o, busy_o
  );
endinterface

// File: rtl/btb_2way.sv
// 2-way set-associative branch target buffer with 2-bit direction counters,
// per-set LRU, zero-latency lookup and a sequential whole-buffer flush.
module btb_2way #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned TAG_W = 22
) (
  input logic        clk,
  input logic        rst_n,
  btb_2way_if.slave  bus
);
  localparam int unsigned NumSets = 2 ** IDX_W;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [NumSets-1:0] valid0_q, valid1_q, lru_q;

  // Payload storage is deliberately not reset; valid bits gate every use.
  logic [TAG_W-1:0] tag_q [2][NumSets];
  logic [29:0]      tgt_q [2][NumSets];
  logic [1:0]       ctr_q [2][NumSets];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;

  assign lk_idx = bus.lk_pc_i[IDX_W+1:2];
  assign lk_tag = bus.lk_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = bus.upd_pc_i[IDX_W+1:2];
  assign up_tag = bus.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lk_pc_i[1:0], bus.upd_pc_i[1:0], bus.upd_target_i[1:0]};

  // Lookup
  logic lk_hit0, lk_hit1, lk_way;
  assign lk_hit0 = valid0_q[lk_idx] && (tag_q[0][lk_idx] == lk_tag);
  assign lk_hit1 = valid1_q[lk_idx] && (tag_q[1][lk_idx] == lk_tag);
  assign lk_way  = ~lk_hit0;

  always_comb begin
    bus.hit_o        = 1'b0;
    bus.pred_taken_o = 1'b0;
    bus.target_o     = '0;
    if (state_q == StIdle && (lk_hit0 || lk_hit1)) begin
      bus.hit_o        = 1'b1;
      bus.pred_taken_o = ctr_q[lk_way][lk_idx][1];
      bus.target_o     = {tgt_q[lk_way][lk_idx], 2'b00};
    end
  end

  assign bus.busy_o = (state_q == StFlush);

  // Update
  logic       up_hit0, up_hit1, up_hit, up_fire, up_wr, up_way;
  logic [1:0] ctr_cur, ctr_new;

  assign up_hit0 = valid0_q[up_idx] && (tag_q[0][up_idx] == up_tag);
  assign up_hit1 = valid1_q[up_idx] && (tag_q[1][up_idx] == up_tag);
  assign up_hit  = up_hit0 || up_hit1;
  // A flush request in the same idle cycle wins over the update.
  assign up_fire = bus.upd_en_i && (state_q == StIdle) && !bus.flush_i;
  assign up_wr   = up_fire && (up_hit || bus.upd_taken_i);

  always_comb begin
    up_way  = 1'b0;
    ctr_cur = '0;
    ctr_new = 2'b10;
    if (up_hit) begin
      up_way  = ~up_hit0;
      ctr_cur = ctr_q[up_way][up_idx];
      if (bus.upd_taken_i) begin
        ctr_new = (ctr_cur == 2'd3) ? 2'd3 : ctr_cur + 2'd1;
      end else begin
        ctr_new = (ctr_cur == 2'd0) ? 2'd0 : ctr_cur - 2'd1;
      end
    end else if (!valid0_q[up_idx]) begin
      up_way = 1'b0;
    end else if (!valid1_q[up_idx]) begin
      up_way = 1'b1;
    end else begin
      up_way = lru_q[up_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (up_wr) begin
      ctr_q[up_way][up_idx] <= ctr_new;
      if (bus.upd_taken_i) tgt_q[up_way][up_idx] <= bus.upd_target_i[31:2];
      if (!up_hit) tag_q[up_way][up_idx] <= up_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.flush_i) begin
            state_q <= StFlush;
          end else if (up_wr) begin
            lru_q[up_idx] <= ~up_way;
            if (!up_hit) begin
              if (up_way) valid1_q[up_idx] <= 1'b1;
              else        valid0_q[up_idx] <= 1'b1;
            end
          end
        end
        StFlush: begin
          valid0_q[cnt_q] <= 1'b0;
          valid1_q[cnt_q] <= 1'b0;
          lru_q[cnt_q]    <= 1'b0;
          cnt_q           <= cnt_q + IDX_W'(1);
          if (cnt_q == '1) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_btb_2way.sv
// Directed bench for btb_2way: per-cycle vector table for lookup/update,
// hand sequences for flush timing, dropped updates and reset mid-flush.
module tb_btb_2way;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btb_2way_if btb_bus ();

  btb_2way #(.IDX_W(8), .TAG_W(22)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (btb_bus)
  );

  typedef struct {
    logic        ue;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic [31:0] lk;
    logic        eh;
    logic        ep;
    logic [31:0] et;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;
  vec_t vecs[$];

  function automatic vec_t mk(logic ue, logic [31:0] upc, logic ut, logic [31:0] utg,
                              logic [31:0] lk, logic eh, logic ep, logic [31:0] et);
    vec_t v;
    v.ue = ue; v.upc = upc; v.ut = ut; v.utg = utg;
    v.lk = lk; v.eh = eh; v.ep = ep; v.et = et;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic eh,
                      input logic ep, input logic [31:0] et);
    btb_bus.lk_pc_i = pc;
    #1;
    chk({nm, ".hit"}, 32'(btb_bus.hit_o), 32'(eh));
    chk({nm, ".pred"}, 32'(btb_bus.pred_taken_o), 32'(ep));
    chk({nm, ".tgt"}, btb_bus.target_o, et);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    btb_bus.upd_en_i = 1'b1; btb_bus.upd_pc_i = pc;
    btb_bus.upd_taken_i = t; btb_bus.upd_target_i = tg;
    @(posedge clk); #1;
    btb_bus.upd_en_i = 1'b0;
  endtask

  initial begin
    int n, hits, preds;
    btb_bus.lk_pc_i = '0; btb_bus.upd_en_i = 1'b0; btb_bus.upd_pc_i = '0;
    btb_bus.upd_taken_i = 1'b0; btb_bus.upd_target_i = '0; btb_bus.flush_i = 1'b0;

    // ue, upd_pc, taken, upd_tgt, lk_pc, exp hit, exp pred, exp tgt (pre-edge state)
    vecs.push_back(mk(0, 0,          0, 0,          32'h1004, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1004,   1, 32'h2003,   32'h1004, 0, 0, 0));
    vecs.push_back(mk(0, 0,          0, 0,          32'h1004, 1, 1, 32'h2000));
    vecs.push_back(mk(0, 0,          0, 0,          32'h1008, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1004,   0, 32'h5550,   32'h1004, 1, 1, 32'h2000));
    vecs.push_back(mk(1, 32'h1004,   0, 32'h5550,   32'h1004, 1, 0, 32'h2000));
    vecs.push_back(mk(1, 32'h1004,   0, 32'h5550,   32'h1004, 1, 0, 32'h2000));
    vecs.push_back(mk(1, 32'h1004,   1, 32'h2103,   32'h1004, 1, 0, 32'h2000));
    vecs.push_back(mk(1, 32'h1004,   1, 32'h2203,   32'h1004, 1, 0, 32'h2100));
    vecs.push_back(mk(1, 32'h1004,   1, 32'h2003,   32'h1004, 1, 1, 32'h2200));
    vecs.push_back(mk(1, 32'h1004,   1, 32'h2003,   32'h1004, 1, 1, 32'h2000));
    vecs.push_back(mk(1, 32'h1004,   0, 32'h5550,   32'h1004, 1, 1, 32'h2000));
    vecs.push_back(mk(0, 0,          0, 0,          32'h1004, 1, 1, 32'h2000));
    vecs.push_back(mk(1, 32'h2004,   1, 32'h6002,   32'h2004, 0, 0, 0));
    vecs.push_back(mk(0, 0,          0, 0,          32'h2004, 1, 1, 32'h6000));
    vecs.push_back(mk(0, 0,          0, 0,          32'h1004, 1, 1, 32'h2000));
    vecs.push_back(mk(1, 32'h3004,   1, 32'h7000,   32'h3004, 0, 0, 0));
    vecs.push_back(mk(0, 0,          0, 0,          32'h1004, 0, 0, 0));
    vecs.push_back(mk(0, 0,          0, 0,          32'h2004, 1, 1, 32'h6000));
    vecs.push_back(mk(0, 0,          0, 0,          32'h3004, 1, 1, 32'h7000));
    vecs.push_back(mk(1, 32'h2004,   0, 0,          32'h2004, 1, 1, 32'h6000));
    vecs.push_back(mk(1, 32'h1004,   1, 32'h8000,   32'h2004, 1, 0, 32'h6000));
    vecs.push_back(mk(0, 0,          0, 0,          32'h3004, 0, 0, 0));
    vecs.push_back(mk(0, 0,          0, 0,          32'h1004, 1, 1, 32'h8000));
    vecs.push_back(mk(0, 0,          0, 0,          32'h2004, 1, 0, 32'h6000));
    vecs.push_back(mk(1, 32'h4000,   0, 32'h9000,   32'h4000, 0, 0, 0));
    vecs.push_back(mk(0, 0,          0, 0,          32'h4000, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4000,   1, 32'h9000,   32'h4000, 0, 0, 0));
    vecs.push_back(mk(0, 0,          0, 0,          32'h4000, 1, 1, 32'h9000));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      btb_bus.upd_en_i = vecs[i].ue; btb_bus.upd_pc_i = vecs[i].upc;
      btb_bus.upd_taken_i = vecs[i].ut; btb_bus.upd_target_i = vecs[i].utg;
      look(nm, vecs[i].lk, vecs[i].eh, vecs[i].ep, vecs[i].et);
      chk({nm, ".busy"}, 32'(btb_bus.busy_o), 32'd0);
      @(posedge clk); #1;
    end
    btb_bus.upd_en_i = 1'b0;

    // Flush together with an update: update dropped, flush starts.
    btb_bus.flush_i = 1'b1;
    btb_bus.upd_en_i = 1'b1; btb_bus.upd_pc_i = 32'h5000;
    btb_bus.upd_taken_i = 1'b1; btb_bus.upd_target_i = 32'hB000;
    @(posedge clk); #1;
    btb_bus.flush_i = 1'b0; btb_bus.upd_en_i = 1'b0;
    btb_bus.lk_pc_i = 32'h1004;
    #1;
    chk("flush.busy_start", 32'(btb_bus.busy_o), 32'd1);
    n = 0; hits = 0; preds = 0;
    while (btb_bus.busy_o && n < 1000) begin
      n++;
      if (btb_bus.hit_o) hits++;
      if (btb_bus.pred_taken_o) preds++;
      if (n == 10) begin
        btb_bus.upd_en_i = 1'b1; btb_bus.upd_pc_i = 32'h6000;
        btb_bus.upd_taken_i = 1'b1; btb_bus.upd_target_i = 32'hD000;
      end
      if (n == 20) btb_bus.flush_i = 1'b1;
      @(posedge clk); #1;
      btb_bus.upd_en_i = 1'b0; btb_bus.flush_i = 1'b0;
      #1;
    end
    chk("flush.busy_cycles", 32'(n), 32'd256);
    chk("flush.hits_while_busy", 32'(hits), 32'd0);
    chk("flush.preds_while_busy", 32'(preds), 32'd0);
    look("post_flush_1004", 32'h1004, 0, 0, 0);
    look("post_flush_2004", 32'h2004, 0, 0, 0);
    look("post_flush_4000", 32'h4000, 0, 0, 0);
    look("dropped_5000", 32'h5000, 0, 0, 0);
    look("dropped_6000", 32'h6000, 0, 0, 0);

    // Updates work again after the flush; 0x13C0 lands in set 0xF0.
    @(posedge clk); #1;
    upd(32'h1004, 1'b1, 32'hA000);
    upd(32'h13C0, 1'b1, 32'hC000);
    look("refill_1004", 32'h1004, 1, 1, 32'hA000);
    look("refill_13c0", 32'h13C0, 1, 1, 32'hC000);

    // Reset around cycle 100 of a flush, before set 0xF0 has been cleared.
    @(posedge clk); #1;
    btb_bus.flush_i = 1'b1;
    @(posedge clk); #1;
    btb_bus.flush_i = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("rst_flush.busy_before", 32'(btb_bus.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_flush.busy_now", 32'(btb_bus.busy_o), 32'd0);
    look("rst_flush.in_reset_13c0", 32'h13C0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    look("rst_flush.13c0", 32'h13C0, 0, 0, 0);
    look("rst_flush.1004", 32'h1004, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flush.busy_after", 32'(btb_bus.busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
